// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, width and FSM definitions for the ALU arbiter.
// Opcodes above OP_IMM are folded to OP_NOP before reaching the ALU.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;
   localparam int CNT_W  = 4;

   typedef logic [OP_W-1:0]   op_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam op_t OP_ADD = 5'd0;
   localparam op_t OP_SUB = 5'd1;
   localparam op_t OP_MUL = 5'd2;
   localparam op_t OP_DIV = 5'd3;
   localparam op_t OP_MOD = 5'd4;
   localparam op_t OP_AND = 5'd5;
   localparam op_t OP_OR  = 5'd6;
   localparam op_t OP_XOR = 5'd7;
   localparam op_t OP_SLL = 5'd8;
   localparam op_t OP_SRL = 5'd9;
   localparam op_t OP_SRA = 5'd10;
   localparam op_t OP_EQ  = 5'd11;
   localparam op_t OP_NE  = 5'd12;
   localparam op_t OP_LT  = 5'd13;
   localparam op_t OP_GE  = 5'd14;
   localparam op_t OP_LTU = 5'd15;
   localparam op_t OP_GEU = 5'd16;
   localparam op_t OP_NOP = 5'd17;
   localparam op_t OP_IMM = 5'd18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic op_t op_sanitize(input op_t op);
      return (op > OP_IMM) ? OP_NOP : op;
   endfunction

   function automatic logic is_divzero(input op_t op, input data_t b);
      return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the shared ALU.
// master = requesters, ALU and response consumer; slave = the arbiter.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic                     Req0_Valid;
   logic                     Req1_Valid;
   logic                     Req0_Ready;
   logic                     Req1_Ready;
   op_t                      Req0_Op;
   op_t                      Req1_Op;
   logic signed [DATA_W-1:0] Req0_A;
   logic signed [DATA_W-1:0] Req1_A;
   logic signed [DATA_W-1:0] Req0_B;
   logic signed [DATA_W-1:0] Req1_B;

   op_t                      ALU_Op;
   logic signed [DATA_W-1:0] ALU_Input_1;
   logic signed [DATA_W-1:0] ALU_Input_2;
   logic signed [DATA_W-1:0] ALU_Result;
   logic                     ALU_True;

   logic                     Rsp_Valid;
   logic                     Rsp_Ready;
   logic                     Rsp_Id;
   logic signed [DATA_W-1:0] Rsp_Result;
   logic                     Rsp_True;
   logic                     Rsp_Error;
   logic                     Busy;

   modport master (
      output Req0_Valid, Req1_Valid,
      output Req0_Op, Req1_Op,
      output Req0_A, Req1_A,
      output Req0_B, Req1_B,
      output ALU_Result, ALU_True,
      output Rsp_Ready,
      input  Req0_Ready, Req1_Ready,
      input  ALU_Op, ALU_Input_1, ALU_Input_2,
      input  Rsp_Valid, Rsp_Id, Rsp_Result,
      input  Rsp_True, Rsp_Error, Busy
   );

   modport slave (
      input  Req0_Valid, Req1_Valid,
      input  Req0_Op, Req1_Op,
      input  Req0_A, Req1_A,
      input  Req0_B, Req1_B,
      input  ALU_Result, ALU_True,
      input  Rsp_Ready,
      output Req0_Ready, Req1_Ready,
      output ALU_Op, ALU_Input_1, ALU_Input_2,
      output Rsp_Valid, Rsp_Id, Rsp_Result,
      output Rsp_True, Rsp_Error, Busy
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with one-hot grant.
// The pointer flips to the loser of each granted cycle when advance is high.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      unique case (valid)
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // after granting 0 the pointer favours 1, and vice versa
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (advance) begin
         ptr <= grant[0];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of the ALU between execute (0) and IO (1).
// Optional ALU_ARB_DIVZERO_CHECK_EN: DIV/MOD by zero answered with Rsp_Error.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int ALU_LATENCY = 1
) (
   input  logic         Fast_Clock,
   input  logic         Reset_N,
   alu_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LATENCY - 1);

   state_t     state;
   logic [CNT_W-1:0] cnt;

   logic [1:0] valid;
   logic [1:0] grant;
   logic       idle;
   logic       accept;
   logic       gnt_id;
   op_t        op_in;
   data_t      a_in;
   data_t      b_in;

   op_t        alu_op_q;
   data_t      in1_q;
   data_t      in2_q;
   logic       rsp_id_q;
   data_t      rsp_res_q;
   logic       rsp_true_q;

   // valids are masked outside IDLE and while reset is asserted
   assign idle  = (state == IDLE) && Reset_N;
   assign valid = {bus.Req1_Valid, bus.Req0_Valid} & {2{idle}};

   rr_arbiter2 u_arb (
      .clk     (Fast_Clock),
      .rst_n   (Reset_N),
      .valid   (valid),
      .advance (accept),
      .grant   (grant)
   );

   assign accept = |grant;
   assign gnt_id = grant[1];

   assign op_in = op_sanitize(gnt_id ? bus.Req1_Op : bus.Req0_Op);
   assign a_in  = gnt_id ? bus.Req1_A : bus.Req0_A;
   assign b_in  = gnt_id ? bus.Req1_B : bus.Req0_B;

`ifdef ALU_ARB_DIVZERO_CHECK_EN
   logic dz;
   logic rsp_err_q;
   assign dz            = is_divzero(op_in, b_in);
   assign bus.Rsp_Error = rsp_err_q;
`else
   assign bus.Rsp_Error = 1'b0;
`endif

   always_ff @(posedge Fast_Clock) begin
      if (!Reset_N) begin
         state      <= IDLE;
         cnt        <= '0;
         alu_op_q   <= OP_NOP;
         in1_q      <= '0;
         in2_q      <= '0;
         rsp_id_q   <= 1'b0;
         rsp_res_q  <= '0;
         rsp_true_q <= 1'b0;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  rsp_id_q <= gnt_id;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
                  if (dz) begin
                     rsp_res_q  <= '0;
                     rsp_true_q <= 1'b0;
                     rsp_err_q  <= 1'b1;
                     state      <= RESP;
                  end else begin
`else
                  begin
`endif
                     alu_op_q <= op_in;
                     in1_q    <= a_in;
                     in2_q    <= b_in;
                     cnt      <= LAT_M1;
                     state    <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_res_q  <= bus.ALU_Result;
                  rsp_true_q <= bus.ALU_True;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
                  rsp_err_q  <= 1'b0;
`endif
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.Rsp_Ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Req0_Ready  = grant[0];
   assign bus.Req1_Ready  = grant[1];
   assign bus.ALU_Op      = alu_op_q;
   assign bus.ALU_Input_1 = in1_q;
   assign bus.ALU_Input_2 = in2_q;
   assign bus.Rsp_Valid   = (state == RESP);
   assign bus.Rsp_Id      = rsp_id_q;
   assign bus.Rsp_Result  = rsp_res_q;
   assign bus.Rsp_True    = rsp_true_q;
   assign bus.Busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter at ALU_LATENCY 1 and 4.
// A behavioural ALU answers the DUT; expected responses queue at accept.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int LAT1 = 1;
   localparam int LAT4 = 4;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic        t;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   logic clk;
   logic rst_n;
   logic rst4_n;
   int   checks;
   int   errors;
   int   cyc;
   int   last_acc;
   logic acc0;
   logic acc1;
   logic rv_q;
   req_t mr;
   rsp_t me;
   rsp_t snap;

   req_t q0[$];
   req_t q1[$];
   rsp_t sb[$];
   int   lat_q[$];
   int   gnt_log[$];
   int   acc_cyc[$];

   alu_arbiter_if b1 ();
   alu_arbiter_if b4 ();

   alu_arbiter #(.ALU_LATENCY(LAT1)) dut (
      .Fast_Clock (clk),
      .Reset_N    (rst_n),
      .bus        (b1)
   );

   alu_arbiter #(.ALU_LATENCY(LAT4)) dut4 (
      .Fast_Clock (clk),
      .Reset_N    (rst4_n),
      .bus        (b4)
   );

   function automatic logic [32:0] alu_f(input logic [4:0] op,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
      logic signed [31:0] r;
      logic t;
      r = '0;
      t = 1'b0;
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_MUL: r = a * b;
         OP_DIV: r = (b == 0) ? 32'sd0 : a / b;
         OP_MOD: r = (b == 0) ? 32'sd0 : a % b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLL: r = a << b[4:0];
         OP_SRL: r = $signed($unsigned(a) >> b[4:0]);
         OP_SRA: r = a >>> b[4:0];
         OP_EQ:  begin t = (a == b); r = {31'b0, t}; end
         OP_NE:  begin t = (a != b); r = {31'b0, t}; end
         OP_LT:  begin t = (a < b);  r = {31'b0, t}; end
         OP_GE:  begin t = (a >= b); r = {31'b0, t}; end
         OP_LTU: begin t = ($unsigned(a) < $unsigned(b));  r = {31'b0, t}; end
         OP_GEU: begin t = ($unsigned(a) >= $unsigned(b)); r = {31'b0, t}; end
         OP_IMM: r = b;
         default: r = '0;
      endcase
      return {t, r};
   endfunction

   function automatic rsp_t exp_rsp(input logic id, input req_t q);
      logic [4:0]  op;
      logic [32:0] tr;
      rsp_t        e;
      op    = (q.op > 5'd18) ? 5'd17 : q.op;
      tr    = alu_f(op, q.a, q.b);
      e.id  = id;
      e.res = tr[31:0];
      e.t   = tr[32];
      e.err = 1'b0;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
      if ((op == 5'd3 || op == 5'd4) && q.b == 32'd0) begin
         e.res = '0;
         e.t   = 1'b0;
         e.err = 1'b1;
      end
`endif
      return e;
   endfunction

   function automatic req_t mk(input logic [4:0] op, input int a, input int b);
      req_t r;
      r.op = op;
      r.a  = 32'(a);
      r.b  = 32'(b);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   assign {b1.ALU_True, b1.ALU_Result} = alu_f(b1.ALU_Op, b1.ALU_Input_1, b1.ALU_Input_2);
   assign {b4.ALU_True, b4.ALU_Result} = alu_f(b4.ALU_Op, b4.ALU_Input_1, b4.ALU_Input_2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // accepts and responses of the latency-1 instance
   always @(negedge clk) begin
      acc0 = rst_n && b1.Req0_Valid && b1.Req0_Ready;
      acc1 = rst_n && b1.Req1_Valid && b1.Req1_Ready;
      if (acc0 || acc1) begin
         mr.op = acc1 ? b1.Req1_Op : b1.Req0_Op;
         mr.a  = acc1 ? b1.Req1_A : b1.Req0_A;
         mr.b  = acc1 ? b1.Req1_B : b1.Req0_B;
         me    = exp_rsp(acc1, mr);
         sb.push_back(me);
         lat_q.push_back(me.err ? 1 : LAT1);
         gnt_log.push_back(acc1 ? 1 : 0);
         acc_cyc.push_back(cyc + 1);
         last_acc = cyc + 1;
      end
      if (rst_n && b1.Rsp_Valid && !rv_q && lat_q.size() != 0)
         chk("latency", 64'(cyc - last_acc), 64'(lat_q[0]));
      if (rst_n && b1.Rsp_Valid && b1.Rsp_Ready) begin
         chk("rsp_pending", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            me = sb.pop_front();
            void'(lat_q.pop_front());
            chk("rsp", 64'({b1.Rsp_Id, b1.Rsp_Result, b1.Rsp_True, b1.Rsp_Error}),
                64'(me));
         end
      end
      rv_q = rst_n && b1.Rsp_Valid;
   end

   task automatic drive();
      b1.Req0_Valid = (q0.size() != 0);
      b1.Req1_Valid = (q1.size() != 0);
      if (q0.size() != 0) begin
         b1.Req0_Op = q0[0].op;
         b1.Req0_A  = q0[0].a;
         b1.Req0_B  = q0[0].b;
      end
      if (q1.size() != 0) begin
         b1.Req1_Op = q1[0].op;
         b1.Req1_A  = q1[0].a;
         b1.Req1_B  = q1[0].b;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      drive();
   endtask

   task automatic run(input int budget);
      int c;
      c = 0;
      while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || b1.Busy)
             && c < budget) begin
         step();
         c++;
      end
      chk("run_budget", 64'(c < budget), 64'(1));
   endtask

   task automatic pulse_rst();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      last_acc = 0;
      rv_q = 1'b0;
      rst_n = 1'b0;
      rst4_n = 1'b0;
      b1.Req0_Valid = 1'b1;
      b1.Req1_Valid = 1'b1;
      b1.Req0_Op = OP_ADD;
      b1.Req1_Op = OP_ADD;
      b1.Req0_A = '0;
      b1.Req1_A = '0;
      b1.Req0_B = '0;
      b1.Req1_B = '0;
      b1.Rsp_Ready = 1'b1;
      b4.Req0_Valid = 1'b0;
      b4.Req1_Valid = 1'b0;
      b4.Req0_Op = OP_ADD;
      b4.Req1_Op = OP_ADD;
      b4.Req0_A = '0;
      b4.Req1_A = '0;
      b4.Req0_B = '0;
      b4.Req1_B = '0;
      b4.Rsp_Ready = 1'b1;

      // reset state with both valids held high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'({b1.Req1_Ready, b1.Req0_Ready}), 64'(0));
      chk("rst_busy", 64'(b1.Busy), 64'(0));
      chk("rst_rsp_valid", 64'(b1.Rsp_Valid), 64'(0));
      chk("rst_alu_op", 64'(b1.ALU_Op), 64'(17));
      chk("rst_alu_in", 64'({b1.ALU_Input_1, b1.ALU_Input_2}), 64'(0));
      chk("rst_rsp", 64'({b1.Rsp_Id, b1.Rsp_Result, b1.Rsp_True, b1.Rsp_Error}),
          64'(0));
      @(posedge clk);
      #1;
      b1.Req0_Valid = 1'b0;
      b1.Req1_Valid = 1'b0;
      rst_n = 1'b1;

      // single op
      gnt_log.delete();
      q0.push_back(mk(OP_ADD, 7, 5));
      run(20);
      chk("single_grants", 64'(gnt_log.size()), 64'(1));

      // contention from reset pointer
      pulse_rst();
      gnt_log.delete();
      acc_cyc.delete();
      q0.push_back(mk(OP_ADD, 1, 2));
      q0.push_back(mk(OP_SUB, 100, 1));
      q0.push_back(mk(OP_MUL, -4, 3));
      q1.push_back(mk(OP_LT, -3, 2));
      q1.push_back(mk(OP_AND, 12, 10));
      q1.push_back(mk(OP_OR, 12, 3));
      run(100);
      for (int i = 0; i < 6; i++)
         chk("grant_order", 64'(i < gnt_log.size() ? gnt_log[i] : 9), 64'(i % 2));
      for (int i = 1; i < 6; i++)
         chk("throughput",
             64'(i < acc_cyc.size() ? acc_cyc[i] - acc_cyc[i-1] : 0),
             64'(LAT1 + 2));

      // back-pressure
      b1.Rsp_Ready = 1'b0;
      q0.push_back(mk(OP_XOR, 240, 255));
      begin
         int n;
         n = 0;
         while (!b1.Rsp_Valid && n < 20) begin
            step();
            n++;
         end
         chk("bp_wait", 64'(n < 20), 64'(1));
      end
      q1.push_back(mk(OP_SLL, 3, 4));
      snap = {b1.Rsp_Id, b1.Rsp_Result, b1.Rsp_True, b1.Rsp_Error};
      repeat (5) begin
         step();
         @(negedge clk);
         chk("bp_hold", 64'({b1.Rsp_Id, b1.Rsp_Result, b1.Rsp_True, b1.Rsp_Error}),
             64'(snap));
         chk("bp_busy", 64'({b1.Busy, b1.Rsp_Valid}), 64'(3));
         chk("bp_no_ready", 64'({b1.Req1_Ready, b1.Req0_Ready}), 64'(0));
      end
      step();
      b1.Rsp_Ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_idle", 64'(b1.Busy), 64'(0));
      chk("bp_regrant", 64'(b1.Req1_Ready), 64'(1));
      run(50);

      // out-of-range opcode and divide by zero
      q0.push_back(mk(5'd25, 3, 4));
      run(20);
      chk("nop_alu_op", 64'(b1.ALU_Op), 64'(17));
      q1.push_back(mk(OP_DIV, 9, 0));
      run(20);
`ifdef ALU_ARB_DIVZERO_CHECK_EN
      chk("dz_alu_op", 64'(b1.ALU_Op), 64'(17));
`else
      chk("dz_alu_op", 64'(b1.ALU_Op), 64'(3));
`endif

      // random mix
      for (int i = 0; i < 16; i++) begin
         req_t r;
         r = mk(5'($urandom_range(0, 31)), int'($urandom_range(0, 200)) - 100,
                int'($urandom_range(0, 4)));
         if ($urandom_range(0, 1) == 0) q0.push_back(r);
         else q1.push_back(r);
      end
      run(400);
      chk("sb_empty", 64'(sb.size()), 64'(0));

      // latency-4 instance: operands held for four cycles
      @(posedge clk);
      #1;
      rst4_n = 1'b1;
      b4.Req0_Valid = 1'b1;
      b4.Req0_Op = OP_SUB;
      b4.Req0_A = 32'd10;
      b4.Req0_B = 32'd3;
      @(negedge clk);
      chk("l4_ready", 64'(b4.Req0_Ready), 64'(1));
      @(posedge clk);
      #1;
      b4.Req0_Valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("l4_alu_hold", 64'({b4.ALU_Op, b4.ALU_Input_1, b4.ALU_Input_2}),
             64'({5'd1, 32'd10, 32'd3}));
         chk("l4_no_rsp", 64'(b4.Rsp_Valid), 64'(0));
      end
      @(negedge clk);
      chk("l4_rsp_valid", 64'(b4.Rsp_Valid), 64'(1));
      chk("l4_rsp", 64'({b4.Rsp_Id, b4.Rsp_Result, b4.Rsp_True, b4.Rsp_Error}),
          64'({1'b0, 32'd7, 1'b0, 1'b0}));
      @(negedge clk);
      chk("l4_idle", 64'(b4.Busy), 64'(0));

      // reset in the middle of EXEC
      @(posedge clk);
      #1;
      b4.Req0_Valid = 1'b1;
      b4.Req0_Op = OP_MUL;
      b4.Req0_A = 32'd6;
      b4.Req0_B = 32'd7;
      @(negedge clk);
      chk("mr_ready", 64'(b4.Req0_Ready), 64'(1));
      @(posedge clk);
      #1;
      b4.Req0_Valid = 1'b0;
      @(posedge clk);
      #1;
      rst4_n = 1'b0;
      b4.Req0_Valid = 1'b1;
      b4.Req1_Valid = 1'b1;
      b4.Req0_Op = OP_ADD;
      b4.Req0_A = 32'd1;
      b4.Req0_B = 32'd1;
      b4.Req1_Op = OP_SUB;
      b4.Req1_A = 32'd5;
      b4.Req1_B = 32'd1;
      @(negedge clk);
      chk("mr_busy_pre", 64'(b4.Busy), 64'(1));
      chk("mr_ready_rst", 64'({b4.Req1_Ready, b4.Req0_Ready}), 64'(0));
      @(negedge clk);
      chk("mr_busy", 64'({b4.Busy, b4.Rsp_Valid}), 64'(0));
      chk("mr_alu", 64'({b4.ALU_Op, b4.ALU_Input_1}), 64'({5'd17, 32'd0}));
      chk("mr_alu_in2", 64'(b4.ALU_Input_2), 64'(0));
      chk("mr_rsp", 64'({b4.Rsp_Id, b4.Rsp_Result, b4.Rsp_True, b4.Rsp_Error}),
          64'(0));
      @(posedge clk);
      #1;
      rst4_n = 1'b1;
      @(negedge clk);
      chk("mr_first_grant", 64'({b4.Req1_Ready, b4.Req0_Ready}), 64'(1));
      @(posedge clk);
      #1;
      b4.Req0_Valid = 1'b0;
      b4.Req1_Valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("mr_no_stale_rsp", 64'(b4.Rsp_Valid), 64'(0));
      end
      @(negedge clk);
      chk("mr_new_rsp", 64'({b4.Rsp_Valid, b4.Rsp_Id, b4.Rsp_Result}),
          64'({1'b1, 1'b0, 32'd2}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single 32-bit processor ALU between two requesters: requester 0 is the core execute stage, requester 1 is the auxiliary/IO unit.
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU operand/opcode inputs for a fixed number of cycles, captures Result/True, and returns them on a response channel tagged with the requester ID.
- Sits between the requesters and the ALU; no other block drives the ALU inputs.

## Interface
Parameters:
- ALU_LATENCY, 1, cycles the ALU inputs are held stable before result capture; legal range 1–15.

Ports:
- Fast_Clock  in  1  system clock; all state updates on rising edge.
- Reset_N  in  1  reset, synchronous, active-low.
- Req0_Valid / Req1_Valid  in  1  request pending.
- Req0_Ready / Req1_Ready  out  1  request accepted this cycle (combinational from state, pointer and valids).
- Req0_Op / Req1_Op  in  5  ALU opcode: 0–18 legal, 19–31 treated as NOP.
- Req0_A / Req1_A  in  32  signed operand 1.
- Req0_B / Req1_B  in  32  signed operand 2.
- ALU_Op  out  5  registered opcode to ALU.
- ALU_Input_1, ALU_Input_2  out  32  registered operands to ALU.
- ALU_Result  in  32  ALU result.
- ALU_True  in  1  ALU compare flag.
- Rsp_Valid  out  1  response available.
- Rsp_Ready  in  1  consumer takes response.
- Rsp_Id  out  1  requester that issued the op.
- Rsp_Result  out  32  captured result.
- Rsp_True  out  1  captured flag.
- Rsp_Error  out  1  op was rejected (see Configuration).
- Busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any ReqX_Valid, assert Ready for exactly one requester.
  - The handshake completes when Valid and Ready are both high at the rising edge.
  - On accept: latch Op/A/B into ALU_Op/ALU_Input_1/ALU_Input_2 and the ID into Rsp_Id, load the counter with ALU_LATENCY-1, go to EXEC.
  - Opcodes 19–31 are latched as 17 (NOP).
- Arbitration:
  - One priority pointer, reset value 0.
  - If both requesters are valid, the pointer's requester wins.
  - After any grant the pointer moves to the other requester.
  - If only one requester is valid, it wins regardless of the pointer.
- EXEC:
  - ALU_* outputs held constant; counter decrements each cycle.
  - When counter = 0: capture ALU_Result/ALU_True into Rsp_Result/Rsp_True, Rsp_Error=0, go to RESP.
- RESP:
  - Rsp_Valid=1; all Rsp_* fields held stable until Rsp_Ready.
  - On Rsp_Valid && Rsp_Ready: go to IDLE.
  - No request is accepted in RESP or EXEC; both Ready outputs are 0.
- ALU_* outputs keep their last value in IDLE/RESP (no toggling).

## Timing
- Reset values:
  - state=IDLE, pointer=0, counter=0.
  - ALU_Op=17 (NOP), ALU_Input_1=ALU_Input_2=0.
  - Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_True=0, Rsp_Error=0, Busy=0.
  - Req0_Ready=Req1_Ready=0 (state is IDLE, but valids are ignored while Reset_N=0).
- Latency: accept edge T → ALU inputs valid from T → capture at edge T+ALU_LATENCY → Rsp_Valid high from T+ALU_LATENCY.
- Throughput: with Rsp_Ready tied high, one op per ALU_LATENCY+2 cycles. The IDLE cycle after RESP is mandatory.
- Back-pressure: Rsp_Ready low holds RESP indefinitely; Busy stays 1.
- A requester dropping Valid before Ready has no effect: nothing is latched.
- Reset mid-EXEC or mid-RESP: the op and response are discarded, all reset values apply at the next edge, and no response is produced.
- Width: operands and result are fixed at 32 bits signed; no extension or truncation.

## Configuration
- Macro: ALU_ARB_DIVZERO_CHECK_EN.
- Defined:
  - An accepted op with opcode 3 (DIV) or 4 (MOD) and B==0 skips EXEC.
  - The next cycle is RESP with Rsp_Result=0, Rsp_True=0, Rsp_Error=1, and ALU_* outputs unchanged.
  - Latency is 1 cycle.
- Undefined:
  - All ops go through EXEC; Rsp_Error is tied 0.

## Structure
- Shared package alu_pkg holds:
  - opcode constants (ADD=0 … IMM=18, NOP=17);
  - the FSM state enum;
  - the DATA_W=32 and OP_W=5 constants.
- Sub-module rr_arbiter2: two-input round-robin arbiter containing the pointer. It takes both valids plus an advance strobe and outputs one-hot grants.
- The FSM, counter and response registers live in the top.

## Test plan
- Single op: Req0 ADD A=7 B=5, ALU_LATENCY=1 → Req0_Ready for one cycle; Rsp_Valid one cycle later with Result=12, Id=0, True=0.
- Contention:
  - Both valid every cycle, pointer at reset → grants alternate 0,1,0,1.
  - Req1 LT A=-3 B=2 → Result=1, True=1, Id=1.
- Back-pressure: Rsp_Ready low for 5 cycles → Rsp fields stable, Busy=1, no Ready pulses; release → IDLE one cycle later.
- Latency parameter: ALU_LATENCY=4, SUB A=10 B=3 → ALU inputs stable for 4 cycles; Rsp_Valid at T+4 with Result=7.
- Reset mid-EXEC: Reset_N low during EXEC of MUL 6×7 → no response; all outputs at reset values; next op grants Req0 first.
- Macro on: DIV A=9 B=0 → Rsp_Error=1, Result=0 one cycle after accept. Macro off, opcode 25 → ALU_Op=17, Result=0.
